// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBrkWait
    } rx_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser for the rx pad followed by a 3-tap majority vote over synced samples.
module uart_rx_sampler (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic synced,
    output logic vote
);

    logic [1:0] sync_q;
    logic [1:0] hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    assign synced = sync_q[1];

    // Majority of the current synced sample and the two before it.
    assign vote = (hist_q[1] & hist_q[0]) | (hist_q[1] & synced) | (hist_q[0] & synced);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity and stop bits, with valid/ready delivery and
// overrun, framing, parity and break status.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter parity_e     PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 break_det,
    output logic                 overrun
);

    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = $clog2(CPB + 1);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] VOTE_AT   = CW'(CPB / 2 + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CPB - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    if (CPB < 8) begin : g_chk_cpb
        $fatal(1, "uart_rx_cfg: clocks per bit must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $fatal(1, "uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $fatal(1, "uart_rx_cfg: STOP_BITS must be 1 or 2");
    end

    logic synced, vote;

    uart_rx_sampler u_sampler (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .synced (synced),
        .vote   (vote)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fe_acc_q, fe_acc_d;
    logic                 pe_acc_q, pe_acc_d;
    logic                 zero_q, zero_d;
    logic                 done_q, done_d;
    logic                 prev_q;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 break_det_q, break_det_d;
    logic                 overrun_q, overrun_d;

    logic at_vote, at_end, par_exp;

    assign at_vote = (cnt_q == VOTE_AT);
    assign at_end  = (cnt_q == LAST_CNT);
    assign par_exp = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        fe_acc_d = fe_acc_q;
        pe_acc_d = pe_acc_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (prev_q && !synced) begin
                    state_d  = StStart;
                    bit_d    = '0;
                    fe_acc_d = 1'b0;
                    pe_acc_d = 1'b0;
                    zero_d   = 1'b1;
                end
            end
            StStart: begin
                if (at_vote && vote) begin
                    state_d = StIdle;
                end else if (at_end) begin
                    state_d = StData;
                    cnt_d   = '0;
                end
            end
            StData: begin
                if (at_vote) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                    zero_d  = zero_q & ~vote;
                end
                if (at_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + BW'(1);
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY == PAR_NONE) ? StStop : StParity;
                    end
                end
            end
            StParity: begin
                if (at_vote) begin
                    pe_acc_d = (vote != par_exp);
                    zero_d   = zero_q & ~vote;
                end
                if (at_end) begin
                    cnt_d   = '0;
                    state_d = StStop;
                end
            end
            StStop: begin
                if (at_vote) begin
                    fe_acc_d = fe_acc_q | ~vote;
                    zero_d   = zero_q & ~vote;
                    // Leave at mid-stop so a back-to-back start edge is never missed.
                    if (bit_q == LAST_STOP) begin
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = (zero_q & ~vote) ? StBrkWait : StIdle;
                    end
                end else if (at_end) begin
                    cnt_d = '0;
                    bit_d = bit_q + BW'(1);
                end
            end
            StBrkWait: begin
                if (!synced) begin
                    cnt_d = '0;
                end else if (at_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        break_det_d  = break_det_q;
        overrun_d    = 1'b0;
        if (done_q) begin
            if (!valid_q || rx_ready) begin
                data_d       = shift_q;
                frame_err_d  = fe_acc_q;
                parity_err_d = pe_acc_q;
                break_det_d  = zero_q;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            fe_acc_q     <= 1'b0;
            pe_acc_q     <= 1'b0;
            zero_q       <= 1'b1;
            done_q       <= 1'b0;
            prev_q       <= 1'b1;
            data_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_det_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            fe_acc_q     <= fe_acc_d;
            pe_acc_q     <= pe_acc_d;
            zero_q       <= zero_d;
            done_q       <= done_d;
            prev_q       <= synced;
            data_q       <= data_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_det_q  <= break_det_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign break_det  = break_det_q;
    assign overrun    = overrun_q;

endmodule
